// File: rtl/uart_tx_reg_file.sv
// Host-facing register file for the UART transmitter: control and TX data registers,
// a sampled status register, registered read-back and a one-cycle transmit start strobe.
module uart_tx_reg_file (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic       wr_addr,
    input  logic       rd_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    input  logic       busy,
    input  logic       uart_tx_done,
    output logic [7:0] tx_p_data,
    output logic       uart_tx_data_valid
);

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned STATUS_W = 2;
    localparam logic        ADDR_CONTROL = 1'b0;
    localparam logic        ADDR_TX_DATA = 1'b1;

    logic [DATA_W-1:0] ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [DATA_W-1:0] status_q,  status_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              valid_q,   valid_d;

    // Next-state: writes win over reads; status samples every cycle.
    always_comb begin
        ctrl_d    = ctrl_q;
        tx_data_d = tx_data_q;
        rd_data_d = rd_data_q;
        valid_d   = 1'b0;
        status_d  = {(DATA_W-STATUS_W)'(0), uart_tx_done, busy};

        if (wr_en) begin
            if (wr_addr == ADDR_CONTROL) begin
                ctrl_d  = wr_data;
                valid_d = wr_data[0];
            end else if (wr_addr == ADDR_TX_DATA) begin
                tx_data_d = wr_data;
            end
        end else if (rd_en) begin
            rd_data_d = rd_addr ? status_q : ctrl_q;
        end
    end

    // State registers; reset drops any pending start strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q    <= '0;
            tx_data_q <= '0;
            status_q  <= '0;
            rd_data_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            tx_data_q <= tx_data_d;
            status_q  <= status_d;
            rd_data_q <= rd_data_d;
            valid_q   <= valid_d;
        end
    end

    assign rd_data            = rd_data_q;
    assign tx_p_data          = tx_data_q;
    assign uart_tx_data_valid = valid_q;

endmodule

// File: tb/tb_uart_tx_reg_file.sv
// Directed bench for uart_tx_reg_file: a register-array reference model checked every
// cycle, plus literal expectations at the interesting points.
module tb_uart_tx_reg_file;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       wr_addr = 1'b0;
    logic       rd_addr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       busy = 1'b0;
    logic       uart_tx_done = 1'b0;
    logic [7:0] tx_p_data;
    logic       uart_tx_data_valid;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_reg_file dut (
        .clk                (clk),
        .rst                (rst),
        .wr_en              (wr_en),
        .rd_en              (rd_en),
        .wr_addr            (wr_addr),
        .rd_addr            (rd_addr),
        .wr_data            (wr_data),
        .rd_data            (rd_data),
        .busy               (busy),
        .uart_tx_done       (uart_tx_done),
        .tx_p_data          (tx_p_data),
        .uart_tx_data_valid (uart_tx_data_valid)
    );

    // Reference model: two host registers indexed by address, a status snapshot,
    // the last read value and the start strobe.
    logic [7:0] m_regs [2];
    logic [7:0] m_status;
    logic [7:0] m_rd;
    logic       m_valid;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_regs[0] <= 8'h00;
            m_regs[1] <= 8'h00;
            m_status  <= 8'h00;
            m_rd      <= 8'h00;
            m_valid   <= 1'b0;
        end else begin
            m_status <= {6'b0, uart_tx_done, busy};
            m_valid  <= wr_en && (wr_addr == 1'b0) && wr_data[0];
            if (wr_en)
                m_regs[wr_addr] <= wr_data;
            else if (rd_en)
                m_rd <= rd_addr ? m_status : m_regs[0];
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("model rd_data", rd_data, m_rd);
            chk("model tx_p_data", tx_p_data, m_regs[1]);
            chk("model valid", {7'b0, uart_tx_data_valid}, {7'b0, m_valid});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        check_en = 1'b1;
        repeat (20) step();
        chk("reset rd_data", rd_data, 8'h00);
        chk("reset tx_p_data", tx_p_data, 8'h00);
        chk("reset valid", {7'b0, uart_tx_data_valid}, 8'h00);
        rst = 1'b1;
        step();

        // wr_en low: no register may change
        for (int a = 0; a < 2; a++) begin
            for (int d = 0; d < 256; d++) begin
                wr_addr = a[0];
                wr_data = d[7:0];
                step();
            end
        end
        chk("no-write tx_p_data", tx_p_data, 8'h00);
        rd_en = 1'b1; rd_addr = 1'b0;
        step(); @(negedge clk);
        chk("no-write control", rd_data, 8'h00);
        step();
        idle();

        // rd_en low: rd_data holds despite live status
        busy = 1'b1; uart_tx_done = 1'b1; rd_addr = 1'b1;
        repeat (4) step();
        chk("no-read rd_data", rd_data, 8'h00);

        // write beats read in the same cycle
        wr_en = 1'b1; rd_en = 1'b1; wr_addr = 1'b1; wr_data = 8'h04; rd_addr = 1'b1;
        repeat (2) step();
        chk("priority rd_data", rd_data, 8'h00);
        chk("priority tx_p_data", tx_p_data, 8'h04);
        idle();
        step();

        // status read-back, two-cycle latency
        rd_en = 1'b1; rd_addr = 1'b1;
        for (int s = 0; s < 4; s++) begin
            {uart_tx_done, busy} = s[1:0];
            @(posedge clk); @(posedge clk); @(negedge clk);
            chk("status read", rd_data, {6'b0, s[1:0]});
            #1;
        end
        idle();
        step();

        // write sweep, with a control read-back after every control write
        for (int a = 0; a < 2; a++) begin
            for (int d = 0; d < 256; d++) begin
                wr_en = 1'b1; wr_addr = a[0]; wr_data = d[7:0];
                step();
                wr_en = 1'b0;
                if (a == 0) begin
                    rd_en = 1'b1; rd_addr = 1'b0;
                    step();
                    rd_en = 1'b0;
                end
            end
        end
        chk("sweep tx_p_data", tx_p_data, 8'hFF);
        rd_en = 1'b1; rd_addr = 1'b0;
        step(); @(negedge clk);
        chk("sweep control", rd_data, 8'hFF);
        step();
        idle();

        // back-to-back start writes, then an even one
        wr_en = 1'b1; wr_addr = 1'b0; wr_data = 8'h01;
        step(); @(negedge clk);
        chk("b2b valid 1", {7'b0, uart_tx_data_valid}, 8'h01);
        #1 wr_data = 8'h03;
        step(); @(negedge clk);
        chk("b2b valid 2", {7'b0, uart_tx_data_valid}, 8'h01);
        #1 wr_data = 8'hA4;
        step(); @(negedge clk);
        chk("even write no valid", {7'b0, uart_tx_data_valid}, 8'h00);
        #1 idle();
        rd_en = 1'b1; rd_addr = 1'b0;
        step(); @(negedge clk);
        chk("control A4", rd_data, 8'hA4);
        #1 idle();

        // reset mid-operation drops the pending strobe
        wr_en = 1'b1; wr_addr = 1'b0; wr_data = 8'h81;
        step();
        idle();
        #1;
        chk("pre-reset valid", {7'b0, uart_tx_data_valid}, 8'h01);
        rst = 1'b0;
        #1;
        chk("mid-reset valid", {7'b0, uart_tx_data_valid}, 8'h00);
        chk("mid-reset tx_p_data", tx_p_data, 8'h00);
        chk("mid-reset rd_data", rd_data, 8'h00);
        repeat (2) step();
        rst = 1'b1;
        rd_en = 1'b1; rd_addr = 1'b0;
        step(); @(negedge clk);
        chk("post-reset control", rd_data, 8'h00);
        #1 idle();
        step();

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
